clock_gen: RTL and testbench

CLOCK_GEN -- requirements
Module: clock_gen

---
 rtl/clock_gen_pkg.sv | 16 +
 rtl/clk_div_counter.sv | 28 ++
 rtl/clock_gen.sv | 81 ++++++++
 tb/tb_clock_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/clock_gen_pkg.sv
// Shared constants and divide-ratio helpers for the clock generator.
package clock_gen_pkg;

    localparam int DEFAULT_IN_FREQ_HZ  = 50_000_000;
    localparam int DEFAULT_OUT_FREQ_HZ = 25_000_000;

    function automatic int calc_div(input int in_hz, input int out_hz);
        return (out_hz > 0) ? in_hz / out_hz : 0;
    endfunction

    // A ratio is usable only when it is an exact integer of at least 2.
    function automatic bit div_is_valid(input int in_hz, input int out_hz);
        return (out_hz > 0) && (in_hz % out_hz == 0) && (in_hz / out_hz >= 2);
    endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Free-running modulo-DIV counter; wrap flags the last count of each period.
module clk_div_counter
    import clock_gen_pkg::*;
#(
    parameter int DIV = 2,
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

    assign wrap = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clock_gen.sv
// 50% duty integer clock divider with a per-period enable strobe and lock flag;
// odd ratios stretch the high phase by half a reference period via a negedge copy.
module clock_gen
    import clock_gen_pkg::*;
#(
    parameter int IN_FREQ_HZ  = DEFAULT_IN_FREQ_HZ,
    parameter int OUT_FREQ_HZ = DEFAULT_OUT_FREQ_HZ
) (
    output logic clk_out,
    input  logic clk,
    input  logic rst_n,
    output logic clk_en,
    output logic locked
);

    localparam bit RATIO_OK = div_is_valid(IN_FREQ_HZ, OUT_FREQ_HZ);
    localparam int DIV      = RATIO_OK ? calc_div(IN_FREQ_HZ, OUT_FREQ_HZ) : 2;
    localparam int CNT_W    = $clog2(DIV);
    localparam bit DIV_ODD  = (DIV % 2) == 1;
    localparam int HIGH_POS = DIV_ODD ? (DIV - 1) / 2 : DIV / 2;
    localparam logic [CNT_W-1:0] HIGH_CNT = CNT_W'(HIGH_POS);

    generate
        if (!RATIO_OK) begin : g_bad_ratio
            $error("clock_gen: IN_FREQ_HZ/OUT_FREQ_HZ must be an exact integer >= 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic             pos_reg;
    logic             clk_en_reg;
    logic             wrap_seen_reg;
    logic             locked_reg;

    clk_div_counter #(.DIV(DIV)) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    // Decisions use the count sampled at the edge, so the edge seeing cnt==0
    // is the one that raises clk_out and fires clk_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_reg       <= 1'b0;
            clk_en_reg    <= 1'b0;
            wrap_seen_reg <= 1'b0;
            locked_reg    <= 1'b0;
        end else begin
            pos_reg       <= (cnt < HIGH_CNT);
            clk_en_reg    <= (cnt == '0);
            wrap_seen_reg <= wrap_seen_reg | wrap;
            locked_reg    <= locked_reg | wrap_seen_reg;
        end
    end

    generate
        if (DIV_ODD) begin : g_odd
            logic neg_reg;

            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    neg_reg <= 1'b0;
                end else begin
                    neg_reg <= pos_reg;
                end
            end

            // Both inputs overlap across each posedge hand-off, so the OR cannot glitch.
            assign clk_out = pos_reg | neg_reg;
        end else begin : g_even
            assign clk_out = pos_reg;
        end
    endgenerate

    assign clk_en = clk_en_reg;
    assign locked = locked_reg;

endmodule

// File: tb/tb_clock_gen.sv
// Directed bench for clock_gen at DIV=2 (defaults), DIV=4 and DIV=3.
module tb_clock_gen;

    logic clk;
    logic rst_n;
    logic out2, en2, lk2;
    logic out4, en4, lk4;
    logic out3, en3, lk3;

    int total;
    int bad;

    int rise2, rise4, rise3;
    int enc2, enc4, enc3;

    clock_gen dut2 (
        .clk_out (out2),
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (en2),
        .locked  (lk2)
    );

    clock_gen #(.IN_FREQ_HZ(100_000_000), .OUT_FREQ_HZ(25_000_000)) dut4 (
        .clk_out (out4),
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (en4),
        .locked  (lk4)
    );

    clock_gen #(.IN_FREQ_HZ(75_000_000), .OUT_FREQ_HZ(25_000_000)) dut3 (
        .clk_out (out3),
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (en3),
        .locked  (lk3)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        rise2 = 0; rise4 = 0; rise3 = 0;
        enc2 = 0; enc4 = 0; enc3 = 0;
    end

    always @(posedge out2) rise2 = rise2 + 1;
    always @(posedge out4) rise4 = rise4 + 1;
    always @(posedge out3) rise3 = rise3 + 1;

    always @(negedge clk) begin
        if (en2) enc2 = enc2 + 1;
        if (en4) enc4 = enc4 + 1;
        if (en3) enc3 = enc3 + 1;
    end

    // Hold reset across one posedge, then release midway through a low phase.
    task automatic release_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #5;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        rst_n = 1'b0;
        #1;
        got = {out2, en2, lk2, out4, en4, lk4, out3, en3, lk3};
        total++;
        if (got !== 9'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=%b", got, 9'b0);
        end
        $display("reset: outputs=%b", got);
    endtask

    task automatic test_divide();
        logic [0:7] e2_out, e2_en, e2_lk;
        logic [0:7] e4_out, e4_en, e4_lk;
        logic [0:7] e3_out, e3_en, e3_lk, e3_neg;
        e2_out = 8'b10101010; e2_en = 8'b10101010; e2_lk = 8'b00111111;
        e4_out = 8'b11001100; e4_en = 8'b10001000; e4_lk = 8'b00001111;
        e3_out = 8'b11011011; e3_en = 8'b10010010; e3_lk = 8'b00011111;
        e3_neg = 8'b10010010;
        release_reset();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            total += 9;
            if (out2 !== e2_out[k]) begin bad++; $display("FAIL div2_clk_out edge=%0d got=%b want=%b", k + 1, out2, e2_out[k]); end
            if (en2  !== e2_en[k])  begin bad++; $display("FAIL div2_clk_en edge=%0d got=%b want=%b", k + 1, en2, e2_en[k]); end
            if (lk2  !== e2_lk[k])  begin bad++; $display("FAIL div2_locked edge=%0d got=%b want=%b", k + 1, lk2, e2_lk[k]); end
            if (out4 !== e4_out[k]) begin bad++; $display("FAIL div4_clk_out edge=%0d got=%b want=%b", k + 1, out4, e4_out[k]); end
            if (en4  !== e4_en[k])  begin bad++; $display("FAIL div4_clk_en edge=%0d got=%b want=%b", k + 1, en4, e4_en[k]); end
            if (lk4  !== e4_lk[k])  begin bad++; $display("FAIL div4_locked edge=%0d got=%b want=%b", k + 1, lk4, e4_lk[k]); end
            if (out3 !== e3_out[k]) begin bad++; $display("FAIL div3_clk_out_pos edge=%0d got=%b want=%b", k + 1, out3, e3_out[k]); end
            if (en3  !== e3_en[k])  begin bad++; $display("FAIL div3_clk_en edge=%0d got=%b want=%b", k + 1, en3, e3_en[k]); end
            if (lk3  !== e3_lk[k])  begin bad++; $display("FAIL div3_locked edge=%0d got=%b want=%b", k + 1, lk3, e3_lk[k]); end
            $display("edge %0d: d2=%b%b%b d4=%b%b%b d3=%b%b%b", k + 1,
                     out2, en2, lk2, out4, en4, lk4, out3, en3, lk3);
            @(negedge clk);
            #1;
            total++;
            if (out3 !== e3_neg[k]) begin
                bad++;
                $display("FAIL div3_clk_out_neg edge=%0d got=%b want=%b", k + 1, out3, e3_neg[k]);
            end
            $display("negedge %0d: d3 clk_out=%b", k + 1, out3);
        end
    endtask

    task automatic test_mid_reset();
        logic [8:0] got;
        release_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        // All three outputs are in their high phase here (d3 via the negedge copy).
        got = {out2, out4, out3};
        total++;
        if (got[2:0] !== 3'b111) begin
            bad++;
            $display("FAIL midreset_high_before got=%b want=%b", got[2:0], 3'b111);
        end
        rst_n = 1'b0;
        #1;
        got = {out2, en2, lk2, out4, en4, lk4, out3, en3, lk3};
        total++;
        if (got !== 9'b0) begin
            bad++;
            $display("FAIL midreset_async_clear got=%b want=%b", got, 9'b0);
        end
        $display("mid-reset: outputs=%b", got);
        @(posedge clk);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got = {out2, en2, lk2, out4, en4, lk4, out3, en3, lk3};
        total++;
        if (got !== 9'b110110110) begin
            bad++;
            $display("FAIL midreset_first_edge got=%b want=%b", got, 9'b110110110);
        end
        $display("restart edge 1: outputs=%b", got);
        @(posedge clk);
        #1;
        got = {out2, en2, lk2, out4, en4, lk4, out3, en3, lk3};
        total++;
        if (got !== 9'b000100100) begin
            bad++;
            $display("FAIL midreset_second_edge got=%b want=%b", got, 9'b000100100);
        end
        $display("restart edge 2: outputs=%b", got);
    endtask

    task automatic test_count();
        int r2, r4, r3, c2, c4, c3;
        rst_n = 1'b0;
        @(posedge clk);
        #5;
        r2 = rise2; r4 = rise4; r3 = rise3;
        c2 = enc2;  c4 = enc4;  c3 = enc3;
        rst_n = 1'b1;
        repeat (1200) @(posedge clk);
        @(negedge clk);
        #1;
        r2 = rise2 - r2; r4 = rise4 - r4; r3 = rise3 - r3;
        c2 = enc2 - c2;  c4 = enc4 - c4;  c3 = enc3 - c3;
        total += 6;
        if (r2 !== 600) begin bad++; $display("FAIL count_div2_rises got=%0d want=%0d", r2, 600); end
        if (r4 !== 300) begin bad++; $display("FAIL count_div4_rises got=%0d want=%0d", r4, 300); end
        if (r3 !== 400) begin bad++; $display("FAIL count_div3_rises got=%0d want=%0d", r3, 400); end
        if (c2 !== 600) begin bad++; $display("FAIL count_div2_en got=%0d want=%0d", c2, 600); end
        if (c4 !== 300) begin bad++; $display("FAIL count_div4_en got=%0d want=%0d", c4, 300); end
        if (c3 !== 400) begin bad++; $display("FAIL count_div3_en got=%0d want=%0d", c3, 400); end
        $display("count 1200 cycles: rises=%0d/%0d/%0d en=%0d/%0d/%0d", r2, r4, r3, c2, c4, c3);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        test_reset();
        test_divide();
        test_mid_reset();
        test_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
